// File: rtl/csc_pkg.sv
// Shared sizing, FSM encodings and the complex sample type for the CSC column packer.
package csc_pkg;
  localparam int MAT_RANK = 256;
  localparam int MAX_NNZ  = 4;
  localparam int IDX_W    = $clog2(MAT_RANK);
  localparam int PTR_W    = $clog2(MAT_RANK*MAX_NNZ+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } cplx_t;
endpackage

// File: rtl/csc_sp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
module csc_sp_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/csc_col_pack.sv
// Collects up to 4 complex non-zeros per column into CSC RAMs, then streams them column-major.
// Drain keeps one read in flight plus a two-slot output/skid buffer so out_rdy stalls never lose data.
module csc_col_pack #(
  parameter int MAT_RANK = csc_pkg::MAT_RANK,
  parameter int MAX_NNZ  = csc_pkg::MAX_NNZ,
  parameter int IDX_W    = $clog2(MAT_RANK),
  parameter int PTR_W    = $clog2(MAT_RANK*MAX_NNZ+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             col_vld,
  output logic             col_rdy,
  input  logic [2:0]       col_cnt,
  input  logic [4*IDX_W-1:0] col_row,
  input  logic [127:0]     col_val_r,
  input  logic [127:0]     col_val_i,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [IDX_W-1:0] out_col,
  output logic [IDX_W-1:0] out_row,
  output logic [31:0]      out_val_r,
  output logic [31:0]      out_val_i,
  output logic             out_last,
  output logic [PTR_W-1:0] nnz_total,
  output logic             done,
  output logic             err
);
  import csc_pkg::*;

  localparam int VDEPTH = MAT_RANK*MAX_NNZ;
  localparam int VAW    = $clog2(VDEPTH);
  localparam int CAW    = $clog2(MAT_RANK+1);
  localparam int EW     = 2*IDX_W + 65;
  localparam logic [CAW-1:0] LAST_COL = CAW'(MAT_RANK);

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [CAW-1:0]   col_idx;
  logic [2:0]       h_n;
  logic [1:0]       k;
  logic [IDX_W-1:0] h_row [4];
  cplx_t            h_val [4];

  logic             col_xfer, wr_last, row_bad;
  logic [2:0]       n_in;
  logic             cp_we;
  logic [CAW-1:0]   cp_waddr, cp_raddr;
  logic [PTR_W-1:0] cp_wdata, cp_rdata;
  cplx_t            v_rdata;
  logic [IDX_W-1:0] r_rdata;

  logic [CAW-1:0]   c, c_nxt;
  logic [PTR_W-1:0] rd_idx, out_cnt;
  logic             p_vld, p_last, sv;
  logic [IDX_W-1:0] p_col;
  logic [EW-1:0]    push_dat, s_dat, out_dat;
  logic             pop, fin, in_col, issue, is_last, adv;
  logic [1:0]       lvl;

  assign col_rdy  = (state == FILL) && (col_idx != LAST_COL);
  assign col_xfer = col_vld && col_rdy;
  assign n_in     = (col_cnt > 3'd4) ? 3'd4 : col_cnt;
  assign wr_last  = (state == WRITE) && (({1'b0, k} + 3'd1) == h_n);
  assign row_bad  = (state == WRITE) && (k != 2'd0) && (h_row[k] <= h_row[k - 2'd1]);

  // col_ptr has a single write port; the three writers are mutually exclusive by state.
  always_comb begin
    cp_we    = 1'b0;
    cp_waddr = col_idx + 1'b1;
    cp_wdata = wr_ptr;
    if (state == IDLE && start) begin
      cp_we    = 1'b1;
      cp_waddr = '0;
      cp_wdata = '0;
    end else if (col_xfer && n_in == 3'd0) begin
      cp_we = 1'b1;
    end else if (wr_last) begin
      cp_we    = 1'b1;
      cp_wdata = wr_ptr + 1'b1;
    end
  end

  csc_sp_ram #(.DEPTH(VDEPTH), .DW(64)) u_val_ram (
    .clk(clk), .we(state == WRITE), .waddr(wr_ptr[VAW-1:0]), .wdata(h_val[k]),
    .raddr(rd_idx[VAW-1:0]), .rdata(v_rdata)
  );

  csc_sp_ram #(.DEPTH(VDEPTH), .DW(IDX_W)) u_row_ram (
    .clk(clk), .we(state == WRITE), .waddr(wr_ptr[VAW-1:0]), .wdata(h_row[k]),
    .raddr(rd_idx[VAW-1:0]), .rdata(r_rdata)
  );

  csc_sp_ram #(.DEPTH(MAT_RANK+1), .DW(PTR_W)) u_ptr_ram (
    .clk(clk), .we(cp_we), .waddr(cp_waddr), .wdata(cp_wdata),
    .raddr(cp_raddr), .rdata(cp_rdata)
  );

  // Read address runs one column ahead of c, so cp_rdata is always col_ptr[c+1] (end of column c).
  assign pop     = out_vld && out_rdy;
  assign fin     = (state == DRAIN) && ((nnz_total == '0) || (pop && (out_cnt + 1'b1) == nnz_total));
  assign in_col  = (state == DRAIN) && (c != LAST_COL) && !fin;
  assign lvl     = {1'b0, out_vld} + {1'b0, sv} + {1'b0, p_vld};
  assign issue   = in_col && (rd_idx != cp_rdata) && ((lvl - {1'b0, pop}) <= 2'd1);
  assign is_last = (rd_idx + 1'b1) == cp_rdata;
  assign adv     = in_col && ((issue && is_last) || (rd_idx == cp_rdata));
  assign c_nxt   = (state == DRAIN && !fin) ? c + CAW'(adv) : '0;
  assign cp_raddr = (c_nxt == LAST_COL) ? c_nxt : c_nxt + 1'b1;

  assign push_dat = {p_col, r_rdata, v_rdata, p_last};
  assign {out_col, out_row, out_val_r, out_val_i, out_last} = out_dat;

  always_ff @(posedge clk) begin
    if (col_xfer) begin
      for (int j = 0; j < 4; j++) begin
        h_row[j]   <= col_row[j*IDX_W +: IDX_W];
        h_val[j].r <= col_val_r[j*32 +: 32];
        h_val[j].i <= col_val_i[j*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      col_idx   <= '0;
      h_n       <= '0;
      k         <= '0;
      rd_idx    <= '0;
      out_cnt   <= '0;
      nnz_total <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wr_ptr    <= '0;
          col_idx   <= '0;
          rd_idx    <= '0;
          out_cnt   <= '0;
          nnz_total <= '0;
          err       <= 1'b0;
          state     <= FILL;
        end
        FILL: if (col_idx == LAST_COL) begin
          nnz_total <= wr_ptr;
          state     <= DRAIN;
        end else if (col_xfer) begin
          h_n <= n_in;
          k   <= '0;
          if (col_cnt > 3'd4) err <= 1'b1;
          if (n_in == 3'd0) col_idx <= col_idx + 1'b1;
          else              state   <= WRITE;
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (row_bad) err <= 1'b1;
          if (wr_last) begin
            col_idx <= col_idx + 1'b1;
            state   <= FILL;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (issue) rd_idx  <= rd_idx + 1'b1;
          if (pop)   out_cnt <= out_cnt + 1'b1;
          if (fin) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c       <= '0;
      p_vld   <= 1'b0;
      p_col   <= '0;
      p_last  <= 1'b0;
      sv      <= 1'b0;
      s_dat   <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      c      <= c_nxt;
      p_vld  <= issue;
      p_col  <= c[IDX_W-1:0];
      p_last <= is_last;
      // Output slot holds while stalled; the skid slot catches the read already in flight.
      if (out_vld && !out_rdy) begin
        if (p_vld) begin
          sv    <= 1'b1;
          s_dat <= push_dat;
        end
      end else if (sv) begin
        out_vld <= 1'b1;
        out_dat <= s_dat;
        sv      <= p_vld;
        if (p_vld) s_dat <= push_dat;
      end else if (p_vld) begin
        out_vld <= 1'b1;
        out_dat <= push_dat;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule
